// File: rtl/shift_exec_stage_pkg.sv
// shift_exec_stage_pkg: shift opcodes, datapath width, variable-amount clamp limit, legality decode
package shift_exec_stage_pkg;
  localparam int SHIFT_W = 32;
  localparam logic [31:0] SHAMT_MAX = 32'd32;
  localparam logic [2:0] OP_SHLL = 3'b000;
  localparam logic [2:0] OP_SHRL = 3'b001;
  localparam logic [2:0] OP_SHRA = 3'b010;
  localparam logic [2:0] OP_SHLLV = 3'b100;
  localparam logic [2:0] OP_SHRLV = 3'b101;
  localparam logic [2:0] OP_SHRAV = 3'b110;
  function automatic logic is_legal(input logic [2:0] op);
    return op[1:0] != 2'b11;
  endfunction
endpackage

// File: rtl/shift.sv
// shift: combinational barrel shifter; in/shamt/is_left/is_arith -> out, amounts >= width give 0 or sign fill
module shift
  import shift_exec_stage_pkg::*;
(
  input  logic [SHIFT_W-1:0] in,
  input  logic [31:0]        shamt,
  input  logic               is_left,
  input  logic               is_arith,
  output logic [SHIFT_W-1:0] out
);
  logic signed [SHIFT_W-1:0] sra;
  assign sra = $signed(in) >>> shamt;
  assign out = is_left ? in << shamt : is_arith ? sra : in >> shamt;
endmodule

// File: rtl/shift_exec_stage.sv
// shift_exec_stage: shift execute slot; in_valid/in_ready/op/rs_data/rt_data/shamt_imm in, 2-entry buffered out_valid/out_ready/result/illegal out
module shift_exec_stage
  import shift_exec_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [31:0]  rs_data,
  input  logic [31:0]  rt_data,
  input  logic [4:0]   shamt_imm,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  result,
  output logic         illegal
);
  logic [31:0] amt, sh_out, res;
  logic [31:0] mem_res [DEPTH];
  logic        mem_ill [DEPTH];
  logic        head, tail, push, pop;
  logic [1:0]  count;
  assign amt = op[2] ? (rt_data > SHAMT_MAX ? SHAMT_MAX : rt_data) : 32'(shamt_imm);
  shift u_shift (
    .in(rs_data),
    .shamt(amt),
    .is_left(~op[1] & ~op[0]),
    .is_arith(op[1]),
    .out(sh_out)
  );
  assign res = is_legal(op) ? sh_out : rs_data;
  assign in_ready = count < 2'(DEPTH);
  assign out_valid = count != 2'd0;
  assign result = out_valid ? mem_res[head] : '0;
  assign illegal = out_valid && mem_ill[head];
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= 1'b0;
      tail <= 1'b0;
      count <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_res[i] <= '0;
        mem_ill[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        mem_res[tail] <= res;
        mem_ill[tail] <= !is_legal(op);
        tail <= ~tail;
      end
      if (pop) head <= ~head;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_shift_exec_stage.sv
module tb_shift_exec_stage;
  import shift_exec_stage_pkg::*;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic [2:0] op = 0;
  logic [31:0] rs_data = 0, rt_data = 0;
  logic [4:0] shamt_imm = 0;
  logic in_ready, out_valid, illegal;
  logic [31:0] result;
  int checks = 0, errors = 0;
  logic [32:0] exp_q [$];

  shift_exec_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .shamt_imm(shamt_imm),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got result %h illegal %b with nothing expected", result, illegal);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({illegal, result} !== e) begin
          errors++;
          $display("FAIL sb_data: got illegal %b result %h expected illegal %b result %h",
                   illegal, result, e[32], e[31:0]);
        end
      end
    end
  end

  task automatic send(input logic [2:0] o, input logic [31:0] rs, input logic [31:0] rt,
                      input logic [4:0] im, input logic [31:0] er, input logic ei);
    int n;
    n = 0;
    op = o; rs_data = rs; rt_data = rt; shamt_imm = im; in_valid = 1;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end else begin
      exp_q.push_back({ei, er});
      @(posedge clk); #1;
    end
    in_valid = 0;
  endtask

  task automatic send_lat(input string name, input logic [2:0] o, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [4:0] im, input logic [31:0] er);
    send(o, rs, rt, im, er, 1'b0);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk(name, result, er);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_result", result, 0);
    chk("rst_illegal", 32'(illegal), 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    send_lat("shll", OP_SHLL, 32'd6541, 0, 5'd3, 32'd52328);
    send_lat("shrl", OP_SHRL, 32'd6541, 0, 5'd3, 32'd817);
    send_lat("shra", OP_SHRA, 32'd6541, 0, 5'd3, 32'd817);
    send_lat("shra_neg", OP_SHRA, 32'hFFFFFFC0, 0, 5'd3, 32'hFFFFFFF8);
    send_lat("shrl_neg", OP_SHRL, 32'hFFFFFFC0, 0, 5'd3, 32'h1FFFFFF8);
    send_lat("shll_neg", OP_SHLL, 32'hFFFFFFC0, 0, 5'd3, 32'hFFFFFE00);
    send_lat("shrav_40", OP_SHRAV, 32'h80000000, 32'd40, 5'd0, 32'hFFFFFFFF);
    send_lat("shllv_32", OP_SHLLV, 32'h1, 32'd32, 5'd0, 32'h0);
    send_lat("shrlv_1", OP_SHRLV, 32'd4, 32'd1, 5'd7, 32'd2);
    send_lat("shra_0", OP_SHRA, 32'h80000001, 0, 5'd0, 32'h80000001);
    send_lat("shrav_big", OP_SHRAV, 32'h40000000, 32'hFFFFFFFF, 5'd0, 32'h0);
    send(3'b011, 32'h12345678, 0, 5'd4, 32'h12345678, 1'b1);
    chk("illegal_flag", 32'(illegal), 1);
    send(OP_SHLL, 32'h1, 0, 5'd1, 32'h2, 1'b0);
    chk("illegal_clear", 32'(illegal), 0);
    send(3'b111, 32'hCAFEF00D, 32'd5, 5'd2, 32'hCAFEF00D, 1'b1);
    // back-to-back throughput with the buffer kept full-speed
    send(OP_SHLL, 32'd1, 0, 5'd1, 32'd2, 1'b0);
    send(OP_SHRL, 32'd8, 0, 5'd1, 32'd4, 1'b0);
    send(OP_SHRLV, 32'd8, 32'd3, 5'd0, 32'd1, 1'b0);
    drain();
    // backpressure: A, B fill the buffer, C waits, one bubble after out_ready rises
    out_ready = 0;
    send(OP_SHLL, 32'd1, 0, 5'd4, 32'd16, 1'b0);
    send(OP_SHRL, 32'h100, 0, 5'd4, 32'h10, 1'b0);
    chk("bp_in_ready_low", 32'(in_ready), 0);
    op = OP_SHLLV; rs_data = 32'd3; rt_data = 32'd1; shamt_imm = 0; in_valid = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("bp_held", 32'(in_ready), 0);
    chk("bp_head_stable", result, 32'd16);
    out_ready = 1;
    #1;
    chk("bp_no_comb_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    chk("bp_bubble_then_ready", 32'(in_ready), 1);
    exp_q.push_back({1'b0, 32'd6});
    @(posedge clk); #1;
    in_valid = 0;
    drain();
    // asynchronous reset with two entries buffered
    out_ready = 0;
    send(OP_SHLL, 32'hA5, 0, 5'd8, 32'hA500, 1'b0);
    send(OP_SHLL, 32'h5A, 0, 5'd8, 32'h5A00, 1'b0);
    #2;
    rst = 1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_result", result, 0);
    exp_q.delete();
    @(posedge clk); #3;
    rst = 0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 1);
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("arst_no_stale", 32'(out_valid), 0);
    end
    send_lat("post_rst", OP_SHRA, 32'h80000000, 0, 5'd31, 32'hFFFFFFFF);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
